// File: rtl/spi_slave_transceiver.sv
// SPI slave endpoint: synchronises SCLK/SS/MOSI into PCLK, shifts one byte
// out on MISO while shifting one in, with a TX holding register and acked RX.
module spi_slave_transceiver #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              spe_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsbfe_i,
  input  logic              sclk_i,
  input  logic              ss_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ack_i,
  output logic              rx_overrun_o,
  output logic              tx_underrun_o,
  output logic              busy_o
);

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE, LOAD, SHIFT, DONE
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   ss_d;

  logic [DATA_W-1:0] hold_q;
  logic              hold_full;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [CW-1:0]     cnt;

  logic sclk_s, ss_s, mosi_s;
  logic sclk_edge, lead_e, trail_e;
  logic sample_e, shift_e;
  logic ss_fall, ss_rise, abort;

  logic [DATA_W-1:0] reload_src;
  logic              reload_bit;
  logic [DATA_W-1:0] tx_adv;
  logic              tx_adv_bit;
  logic [DATA_W-1:0] rx_next;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sclk_sync <= {SYNC_STAGES{cpol_i}};
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= cpol_i;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sclk_edge = sclk_s ^ sclk_d;
  assign lead_e    = sclk_edge & (sclk_d == cpol_i);
  assign trail_e   = sclk_edge & (sclk_s == cpol_i);
  assign sample_e  = cpha_i ? trail_e : lead_e;
  assign shift_e   = cpha_i ? lead_e : trail_e;

  assign ss_fall = ss_d & ~ss_s;
  assign ss_rise = ~ss_d & ss_s;
  assign abort   = ss_rise | ~spe_i;

  assign reload_src = hold_full ? hold_q : '1;
  assign reload_bit = lsbfe_i ? reload_src[0] : reload_src[DATA_W-1];
  assign tx_adv     = lsbfe_i ? (tx_sr >> 1) : (tx_sr << 1);
  assign tx_adv_bit = lsbfe_i ? tx_sr[1] : tx_sr[DATA_W-2];
  assign rx_next    = lsbfe_i ? {mosi_s, rx_sr[DATA_W-1:1]}
                              : {rx_sr[DATA_W-2:0], mosi_s};

  assign tx_ready_o = ~hold_full;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state         <= IDLE;
      hold_q        <= '0;
      hold_full     <= 1'b0;
      tx_sr         <= '0;
      rx_sr         <= '0;
      cnt           <= '0;
      miso_o        <= 1'b0;
      miso_oe_o     <= 1'b0;
      busy_o        <= 1'b0;
      rx_data_o     <= '0;
      rx_valid_o    <= 1'b0;
      rx_overrun_o  <= 1'b0;
      tx_underrun_o <= 1'b0;
    end else begin
      rx_overrun_o  <= 1'b0;
      tx_underrun_o <= 1'b0;
      if (rx_ack_i)
        rx_valid_o <= 1'b0;
      if (tx_valid_i && !hold_full) begin
        hold_q    <= tx_data_i;
        hold_full <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (ss_fall && spe_i) begin
            state     <= LOAD;
            busy_o    <= 1'b1;
            miso_oe_o <= 1'b1;
          end
        end
        LOAD: begin
          if (abort) begin
            state     <= IDLE;
            busy_o    <= 1'b0;
            miso_oe_o <= 1'b0;
            miso_o    <= 1'b0;
            cnt       <= '0;
          end else begin
            tx_sr  <= reload_src;
            miso_o <= reload_bit;
            if (hold_full) hold_full <= 1'b0;
            else tx_underrun_o <= 1'b1;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            state     <= IDLE;
            busy_o    <= 1'b0;
            miso_oe_o <= 1'b0;
            miso_o    <= 1'b0;
            cnt       <= '0;
          end else begin
            if (sample_e) begin
              rx_sr <= rx_next;
              cnt   <= cnt + 1'b1;
              if (cnt == CW'(DATA_W - 1))
                state <= DONE;
            end
            // cnt==0 marks the first shift edge after a reload: bit already out
            if (shift_e && cnt != '0) begin
              tx_sr  <= tx_adv;
              miso_o <= tx_adv_bit;
            end
          end
        end
        DONE: begin
          if (rx_valid_o && !rx_ack_i) begin
            rx_overrun_o <= 1'b1;
          end else begin
            rx_data_o  <= rx_sr;
            rx_valid_o <= 1'b1;
          end
          cnt <= '0;
          if (abort) begin
            state     <= IDLE;
            busy_o    <= 1'b0;
            miso_oe_o <= 1'b0;
            miso_o    <= 1'b0;
          end else begin
            tx_sr  <= reload_src;
            miso_o <= reload_bit;
            if (hold_full) hold_full <= 1'b0;
            else tx_underrun_o <= 1'b1;
            state <= SHIFT;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_transceiver.sv
// Directed bench for spi_slave_transceiver: acts as SPI master on the pins
// and as register-file client on the TX/RX side.
module tb_spi_slave_transceiver;

  localparam int H = 8;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b0;
  logic       spe = 1'b1;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       lsbfe = 1'b0;
  logic       sclk = 1'b0;
  logic       ss = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic       rx_overrun;
  logic       tx_underrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;
  int udr_cnt = 0;
  logic lat_pre, lat_post;

  spi_slave_transceiver #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .spe_i(spe),
    .cpol_i(cpol), .cpha_i(cpha), .lsbfe_i(lsbfe),
    .sclk_i(sclk), .ss_i(ss), .mosi_i(mosi),
    .miso_o(miso), .miso_oe_o(miso_oe),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ack_i(rx_ack),
    .rx_overrun_o(rx_overrun), .tx_underrun_o(tx_underrun),
    .busy_o(busy)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) begin
    if (rx_overrun === 1'b1) ovr_cnt++;
    if (tx_underrun === 1'b1) udr_cnt++;
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic load_tx(input logic [7:0] d);
    @(negedge PCLK);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge PCLK);
    tx_valid = 1'b0;
  endtask

  task automatic ack_rx();
    @(negedge PCLK);
    rx_ack = 1'b1;
    @(negedge PCLK);
    rx_ack = 1'b0;
  endtask

  task automatic set_mode(input logic pol, input logic pha, input logic lsb);
    @(negedge PCLK);
    cpol  = pol;
    cpha  = pha;
    lsbfe = lsb;
    sclk  = pol;
    wait_n(10);
  endtask

  task automatic frame_start();
    @(negedge PCLK);
    ss = 1'b0;
    wait_n(2 * H);
  endtask

  task automatic frame_end();
    wait_n(H);
    ss = 1'b1;
    wait_n(2 * H);
  endtask

  task automatic xfer(input logic [7:0] mo, input int nbits,
                      input bit lat, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      int b;
      b = lsbfe ? i : 7 - i;
      if (!cpha) begin
        mosi = mo[b];
        wait_n(H);
        mi[b] = miso;
        sclk = ~cpol;
        if (lat && i == nbits - 1) begin
          repeat (3) @(posedge PCLK);
          #1 lat_pre = rx_valid;
          @(posedge PCLK);
          #1 lat_post = rx_valid;
        end
        wait_n(H);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = mo[b];
        wait_n(H);
        mi[b] = miso;
        sclk = cpol;
        wait_n(H);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge PCLK);
    PRESET = 1'b1;
    @(posedge PCLK);
    #1;
    checks++;
    if (miso !== 1'b0 || miso_oe !== 1'b0) begin
      errors++;
      $display("FAIL reset_miso: miso=%b oe=%b want 0 0", miso, miso_oe);
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_tx_ready: got %b want 1", tx_ready);
    end
    checks++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_rx: valid=%b data=%h want 0 00", rx_valid, rx_data);
    end
    checks++;
    if (busy !== 1'b0 || rx_overrun !== 1'b0 || tx_underrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b ovr=%b udr=%b want 0 0 0",
               busy, rx_overrun, tx_underrun);
    end
    @(negedge PCLK);
    PRESET = 1'b0;
    wait_n(4);
  endtask

  task automatic test_mode0();
    logic [7:0] mi;
    set_mode(1'b0, 1'b0, 1'b0);
    load_tx(8'hA5);
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL mode0_tx_ready_after_load: got %b want 0", tx_ready);
    end
    frame_start();
    checks++;
    if (busy !== 1'b1 || miso_oe !== 1'b1) begin
      errors++;
      $display("FAIL mode0_busy: busy=%b oe=%b want 1 1", busy, miso_oe);
    end
    xfer(8'h3C, 8, 1'b1, mi);
    frame_end();
    checks++;
    if (mi !== 8'hA5) begin
      errors++;
      $display("FAIL mode0_miso: got %h want a5", mi);
    end
    checks++;
    if (rx_data !== 8'h3C || rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL mode0_rx: data=%h valid=%b want 3c 1", rx_data, rx_valid);
    end
    checks++;
    if (lat_pre !== 1'b0 || lat_post !== 1'b1) begin
      errors++;
      $display("FAIL mode0_latency: at+3=%b at+4=%b want 0 1", lat_pre, lat_post);
    end
    checks++;
    if (busy !== 1'b0 || miso_oe !== 1'b0) begin
      errors++;
      $display("FAIL mode0_idle: busy=%b oe=%b want 0 0", busy, miso_oe);
    end
    ack_rx();
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL mode0_ack: rx_valid=%b want 0", rx_valid);
    end
  endtask

  task automatic test_modes123();
    logic [7:0] mi;
    for (int m = 1; m < 4; m++) begin
      logic [1:0] mb;
      mb = 2'(m);
      set_mode(mb[1], mb[0], 1'b1);
      load_tx(8'h81);
      frame_start();
      xfer(8'h7E, 8, 1'b0, mi);
      frame_end();
      checks++;
      if (mi !== 8'h81) begin
        errors++;
        $display("FAIL mode%0d_miso: got %h want 81", m, mi);
      end
      checks++;
      if (rx_data !== 8'h7E || rx_valid !== 1'b1) begin
        errors++;
        $display("FAIL mode%0d_rx: data=%h valid=%b want 7e 1",
                 m, rx_data, rx_valid);
      end
      ack_rx();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] mi1, mi2;
    set_mode(1'b0, 1'b0, 1'b0);
    load_tx(8'hF0);
    ovr_cnt = 0;
    frame_start();
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_hold_emptied: tx_ready=%b want 1", tx_ready);
    end
    load_tx(8'h55);
    xfer(8'h11, 8, 1'b0, mi1);
    xfer(8'h22, 8, 1'b0, mi2);
    frame_end();
    checks++;
    if (mi1 !== 8'hF0 || mi2 !== 8'h55) begin
      errors++;
      $display("FAIL b2b_miso: got %h %h want f0 55", mi1, mi2);
    end
    checks++;
    if (ovr_cnt !== 1) begin
      errors++;
      $display("FAIL b2b_overrun: pulses=%0d want 1", ovr_cnt);
    end
    checks++;
    if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_rx_kept: data=%h valid=%b want 11 1", rx_data, rx_valid);
    end
    ack_rx();
  endtask

  task automatic test_underrun();
    logic [7:0] mi;
    udr_cnt = 0;
    frame_start();
    checks++;
    if (udr_cnt !== 1) begin
      errors++;
      $display("FAIL underrun_pulse: pulses=%0d want 1", udr_cnt);
    end
    xfer(8'h00, 8, 1'b0, mi);
    frame_end();
    checks++;
    if (mi !== 8'hFF) begin
      errors++;
      $display("FAIL underrun_miso: got %h want ff", mi);
    end
    ack_rx();
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    load_tx(8'h0F);
    frame_start();
    xfer(8'hFF, 3, 1'b0, mi);
    ss = 1'b1;
    wait_n(2 * H);
    checks++;
    if (busy !== 1'b0 || miso_oe !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b oe=%b want 0 0", busy, miso_oe);
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_rx: rx_valid=%b want 0", rx_valid);
    end
    load_tx(8'h3C);
    frame_start();
    xfer(8'hC3, 8, 1'b0, mi);
    frame_end();
    checks++;
    if (rx_data !== 8'hC3 || rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL abort_next_rx: data=%h valid=%b want c3 1", rx_data, rx_valid);
    end
    checks++;
    if (mi !== 8'h3C) begin
      errors++;
      $display("FAIL abort_next_miso: got %h want 3c", mi);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] mi;
    load_tx(8'h99);
    frame_start();
    load_tx(8'h77);
    xfer(8'hFF, 5, 1'b0, mi);
    checks++;
    if (tx_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: ready=%b busy=%b want 0 1", tx_ready, busy);
    end
    @(negedge PCLK);
    PRESET = 1'b1;
    ss     = 1'b1;
    sclk   = cpol;
    @(posedge PCLK);
    #1;
    checks++;
    if (busy !== 1'b0 || miso_oe !== 1'b0 || miso !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle: busy=%b oe=%b miso=%b want 0 0 0",
               busy, miso_oe, miso);
    end
    checks++;
    if (tx_ready !== 1'b1 || rx_valid !== 1'b0 || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL midrst_regs: ready=%b valid=%b data=%h want 1 0 00",
               tx_ready, rx_valid, rx_data);
    end
    @(negedge PCLK);
    PRESET = 1'b0;
    wait_n(6);
    load_tx(8'h5A);
    frame_start();
    xfer(8'h96, 8, 1'b0, mi);
    frame_end();
    checks++;
    if (rx_data !== 8'h96 || rx_valid !== 1'b1 || mi !== 8'h5A) begin
      errors++;
      $display("FAIL midrst_after: rx=%h valid=%b miso=%h want 96 1 5a",
               rx_data, rx_valid, mi);
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes123();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
